// File: rtl/pressure_sample_ctrl.sv
// pressure_sample_ctrl
//   Periodic pressure-sensor sampler. Waits `period` cycles, then raises
//   sample_req until the sensor answers with sample_valid or TIMEOUT cycles
//   pass. It registers the reading into pressure_q and then updates a
//   hysteretic over-pressure alarm.
//
//   Optional feature: define PRESSURE_AVG_EN so that pressure_q and the
//   alarm compare use the average of the latest 4 accepted samples.
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous, active-high reset
//   enable       run/stop for periodic sampling
//   period       cycles between requests (0 treated as 1)
//   thresh_hi    alarm set level
//   thresh_lo    alarm clear level
//   sample_valid sensor data-valid strobe
//   sample_data  sensor reading
//   sample_req   request to sensor (high while waiting)
//   pressure_q   last accepted reading / average
//   new_sample   one-cycle pulse when pressure_q/alarm updated
//   alarm        hysteretic over-pressure flag
//   timeout_err  sticky sensor-timeout flag
module pressure_sample_ctrl #(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [15:0]       period,
  input  logic [DATA_W-1:0] thresh_hi,
  input  logic [DATA_W-1:0] thresh_lo,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              sample_req,
  output logic [DATA_W-1:0] pressure_q,
  output logic              new_sample,
  output logic              alarm,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, COUNT, REQ, EVAL} state_t;

  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

  state_t            state;
  logic [15:0]       cnt;
  logic [15:0]       tcnt;
  logic [15:0]       period_eff;
  logic [DATA_W-1:0] value_next;
  logic              capture;

  assign period_eff = (period == 16'd0) ? 16'd1 : period;
  assign capture    = (state == REQ) && enable && sample_valid;

`ifdef PRESSURE_AVG_EN
  // Only the three older samples are stored; the fourth is the incoming one.
  logic [DATA_W-1:0] hist0, hist1, hist2;
  logic [DATA_W+1:0] sum;

  always_comb begin
    sum        = (DATA_W+2)'(sample_data) + (DATA_W+2)'(hist0)
               + (DATA_W+2)'(hist1) + (DATA_W+2)'(hist2);
    value_next = sum[DATA_W+1:2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist0 <= '0;
      hist1 <= '0;
      hist2 <= '0;
    end else if (capture) begin
      hist0 <= sample_data;
      hist1 <= hist0;
      hist2 <= hist1;
    end
  end
`else
  assign value_next = sample_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      tcnt        <= '0;
      sample_req  <= 1'b0;
      pressure_q  <= '0;
      new_sample  <= 1'b0;
      alarm       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      new_sample <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state       <= COUNT;
            cnt         <= period_eff;
            timeout_err <= 1'b0;
          end
        end
        COUNT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (cnt <= 16'd1) begin
            state      <= REQ;
            cnt        <= '0;
            tcnt       <= '0;
            sample_req <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        REQ: begin
          if (!enable) begin
            state      <= IDLE;
            sample_req <= 1'b0;
          end else if (sample_valid) begin
            // A valid strobe on the expiry cycle is still accepted.
            pressure_q <= value_next;
            sample_req <= 1'b0;
            state      <= EVAL;
          end else if (tcnt == TLAST) begin
            timeout_err <= 1'b1;
            sample_req  <= 1'b0;
            state       <= COUNT;
            cnt         <= period_eff;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        EVAL: begin
          // Set check first so an inverted threshold pair still raises alarm.
          if (pressure_q > thresh_hi)      alarm <= 1'b1;
          else if (pressure_q < thresh_lo) alarm <= 1'b0;
          new_sample <= 1'b1;
          if (enable) begin
            state <= COUNT;
            cnt   <= period_eff;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pressure_sample_ctrl.sv
module tb_pressure_sample_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] period;
  logic [11:0] thresh_hi;
  logic [11:0] thresh_lo;
  logic        sample_valid;
  logic [11:0] sample_data;
  logic        sample_req;
  logic [11:0] pressure_q;
  logic        new_sample;
  logic        alarm;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  pressure_sample_ctrl #(.DATA_W(12), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .thresh_hi(thresh_hi), .thresh_lo(thresh_lo),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_req(sample_req), .pressure_q(pressure_q),
    .new_sample(new_sample), .alarm(alarm), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sample_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; period = 16'd4;
    thresh_hi = 12'd800; thresh_lo = 12'd700;
    sample_valid = 1'b0; sample_data = '0;
    tick(); tick();
    total++; if (sample_req !== 1'b0) begin bad++; $display("FAIL rst_sample_req got=%b exp=0", sample_req); end
    total++; if (pressure_q !== 12'd0) begin bad++; $display("FAIL rst_pressure_q got=%0d exp=0", pressure_q); end
    total++; if (new_sample !== 1'b0) begin bad++; $display("FAIL rst_new_sample got=%b exp=0", new_sample); end
    total++; if (alarm !== 1'b0) begin bad++; $display("FAIL rst_alarm got=%b exp=0", alarm); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout_err got=%b exp=0", timeout_err); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total++; if (sample_req !== 1'b0) begin bad++; $display("FAIL first_req_early got=%b exp=0", sample_req); end
    tick();
    total++; if (sample_req !== 1'b1) begin bad++; $display("FAIL first_req_rise got=%b exp=1", sample_req); end
  endtask

  task automatic test_alarm();
    logic [11:0] vals [9] = '{12'd750, 12'd810, 12'd750, 12'd690, 12'd700, 12'd800, 12'd801, 12'd699, 12'd150};
    logic [11:0] his  [9] = '{12'd800, 12'd800, 12'd800, 12'd800, 12'd800, 12'd800, 12'd800, 12'd800, 12'd100};
    logic [11:0] los  [9] = '{12'd700, 12'd700, 12'd700, 12'd700, 12'd700, 12'd700, 12'd700, 12'd700, 12'd200};
    logic        exps [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bit ok;
    for (int i = 0; i < 9; i++) begin
      thresh_hi = his[i]; thresh_lo = los[i];
      wait_req(ok);
      total++; if (!ok) begin bad++; $display("FAIL alarm_wait_req[%0d] got=timeout exp=sample_req", i); end
      sample_valid = 1'b1; sample_data = vals[i];
      tick();
      sample_valid = 1'b0;
      total++; if (pressure_q !== vals[i]) begin bad++; $display("FAIL alarm_pq[%0d] got=%0d exp=%0d", i, pressure_q, vals[i]); end
      total++; if (sample_req !== 1'b0) begin bad++; $display("FAIL alarm_req_drop[%0d] got=%b exp=0", i, sample_req); end
      total++; if (new_sample !== 1'b0) begin bad++; $display("FAIL alarm_ns_early[%0d] got=%b exp=0", i, new_sample); end
      tick();
      total++; if (new_sample !== 1'b1) begin bad++; $display("FAIL alarm_ns_pulse[%0d] got=%b exp=1", i, new_sample); end
      total++; if (alarm !== exps[i]) begin bad++; $display("FAIL alarm_val[%0d] got=%b exp=%b", i, alarm, exps[i]); end
      tick();
      total++; if (new_sample !== 1'b0) begin bad++; $display("FAIL alarm_ns_width[%0d] got=%b exp=0", i, new_sample); end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    wait_req(ok);
    total++; if (!ok) begin bad++; $display("FAIL to_wait_req got=timeout exp=sample_req"); end
    for (int i = 0; i < 15; i++) tick();
    total++; if (sample_req !== 1'b1) begin bad++; $display("FAIL to_req_held got=%b exp=1", sample_req); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_err_early got=%b exp=0", timeout_err); end
    tick();
    total++; if (sample_req !== 1'b0) begin bad++; $display("FAIL to_req_drop got=%b exp=0", sample_req); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_err_set got=%b exp=1", timeout_err); end
    for (int i = 0; i < 3; i++) tick();
    total++; if (sample_req !== 1'b0) begin bad++; $display("FAIL to_rereq_early got=%b exp=0", sample_req); end
    tick();
    total++; if (sample_req !== 1'b1) begin bad++; $display("FAIL to_rereq got=%b exp=1", sample_req); end
    sample_valid = 1'b1; sample_data = 12'd500;
    tick();
    sample_valid = 1'b0;
    total++; if (pressure_q !== 12'd500) begin bad++; $display("FAIL to_pq got=%0d exp=500", pressure_q); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_err_sticky got=%b exp=1", timeout_err); end
    tick();
    total++; if (alarm !== 1'b1) begin bad++; $display("FAIL to_alarm got=%b exp=1", alarm); end
    tick();
    // valid on the expiry cycle must be captured
    wait_req(ok);
    total++; if (!ok) begin bad++; $display("FAIL exp_wait_req got=timeout exp=sample_req"); end
    for (int i = 0; i < 15; i++) tick();
    sample_valid = 1'b1; sample_data = 12'd600;
    tick();
    sample_valid = 1'b0;
    total++; if (pressure_q !== 12'd600) begin bad++; $display("FAIL exp_pq got=%0d exp=600", pressure_q); end
    tick();
    total++; if (new_sample !== 1'b1) begin bad++; $display("FAIL exp_ns got=%b exp=1", new_sample); end
  endtask

  task automatic test_abort();
    bit ok;
    wait_req(ok);
    total++; if (!ok) begin bad++; $display("FAIL ab_wait_req got=timeout exp=sample_req"); end
    enable = 1'b0;
    tick();
    total++; if (sample_req !== 1'b0) begin bad++; $display("FAIL ab_req_drop got=%b exp=0", sample_req); end
    total++; if (pressure_q !== 12'd600) begin bad++; $display("FAIL ab_pq_kept got=%0d exp=600", pressure_q); end
    total++; if (alarm !== 1'b1) begin bad++; $display("FAIL ab_alarm_kept got=%b exp=1", alarm); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL ab_err_kept got=%b exp=1", timeout_err); end
    tick(); tick();
    sample_valid = 1'b1; sample_data = 12'd123;
    tick();
    sample_valid = 1'b0;
    total++; if (new_sample !== 1'b0) begin bad++; $display("FAIL ab_idle_ns0 got=%b exp=0", new_sample); end
    total++; if (pressure_q !== 12'd600) begin bad++; $display("FAIL ab_idle_pq got=%0d exp=600", pressure_q); end
    tick();
    total++; if (new_sample !== 1'b0) begin bad++; $display("FAIL ab_idle_ns1 got=%b exp=0", new_sample); end
    enable = 1'b1;
    tick();
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL ab_err_clear got=%b exp=0", timeout_err); end
    for (int i = 0; i < 3; i++) tick();
    total++; if (sample_req !== 1'b0) begin bad++; $display("FAIL ab_restart_early got=%b exp=0", sample_req); end
    tick();
    total++; if (sample_req !== 1'b1) begin bad++; $display("FAIL ab_restart_req got=%b exp=1", sample_req); end
  endtask

  task automatic test_period_zero();
    bit ok;
    period = 16'd0;
    wait_req(ok);
    total++; if (!ok) begin bad++; $display("FAIL p0_wait_req got=timeout exp=sample_req"); end
    sample_valid = 1'b1; sample_data = 12'd300;
    tick();
    sample_valid = 1'b0;
    tick();
    total++; if (new_sample !== 1'b1) begin bad++; $display("FAIL p0_ns got=%b exp=1", new_sample); end
    tick();
    total++; if (sample_req !== 1'b1) begin bad++; $display("FAIL p0_req_after_1 got=%b exp=1", sample_req); end
  endtask

  task automatic test_avg();
    logic [11:0] exp_q [4];
    bit ok;
`ifdef PRESSURE_AVG_EN
    exp_q = '{12'd100, 12'd200, 12'd300, 12'd400};
`else
    exp_q = '{12'd400, 12'd400, 12'd400, 12'd400};
`endif
    // asynchronous reset mid-cycle while in REQ
    reset = 1'b1;
    #1;
    total++; if (sample_req !== 1'b0) begin bad++; $display("FAIL async_rst_req got=%b exp=0", sample_req); end
    total++; if (pressure_q !== 12'd0) begin bad++; $display("FAIL async_rst_pq got=%0d exp=0", pressure_q); end
    total++; if (alarm !== 1'b0) begin bad++; $display("FAIL async_rst_alarm got=%b exp=0", alarm); end
    period = 16'd2;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_req(ok);
      total++; if (!ok) begin bad++; $display("FAIL avg_wait_req[%0d] got=timeout exp=sample_req", i); end
      sample_valid = 1'b1; sample_data = 12'd400;
      tick();
      sample_valid = 1'b0;
      total++; if (pressure_q !== exp_q[i]) begin bad++; $display("FAIL avg_pq[%0d] got=%0d exp=%0d", i, pressure_q, exp_q[i]); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alarm();
    test_timeout();
    test_abort();
    test_period_zero();
    test_avg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
